// File: rtl/ibex_l2rf_pkg.sv
// Shared types and constants for the L2 register-file bank.
package ibex_l2rf_pkg;

    localparam int unsigned RegAddrW = 5;
    localparam int unsigned NumRegs  = 1 << RegAddrW;
    // Holds ReadLatency-1 for the legal latency range 1..4
    localparam int unsigned LatCntW  = 2;
    // Occupancy counter covers 0..4 entries
    localparam int unsigned WbLevelW = 3;
    // Widest data payload a write-buffer entry can carry
    localparam int unsigned MaxDataW = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } l2rf_state_e;

    typedef struct packed {
        logic [RegAddrW-1:0] addr;
        logic [MaxDataW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/ibex_l2rf_wbuf.sv
// Posted write buffer: FIFO of {addr, data} with youngest-match lookup for forwarding.
module ibex_l2rf_wbuf
    import ibex_l2rf_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned WbDepth   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_push,
    input  logic [RegAddrW-1:0]  i_push_addr,
    input  logic [DataWidth-1:0] i_push_data,
    input  logic                 i_pop,
    output logic [RegAddrW-1:0]  o_pop_addr,
    output logic [DataWidth-1:0] o_pop_data,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [WbLevelW-1:0]  o_level,
    input  logic [RegAddrW-1:0]  i_lookup_addr,
    output logic                 o_lookup_hit,
    output logic [DataWidth-1:0] o_lookup_data
);

    localparam int unsigned PtrW = (WbDepth > 1) ? $clog2(WbDepth) : 1;

    wb_entry_t           r_mem [WbDepth];
    logic [PtrW-1:0]     r_wr_ptr;
    logic [PtrW-1:0]     r_rd_ptr;
    logic [WbLevelW-1:0] r_level;
    logic [PtrW-1:0]     w_idx;

    // Pointers wrap modulo WbDepth, which need not be a power of two
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (32'(p) == WbDepth - 1) ? '0 : p + 1'b1;
    endfunction

    // Entry storage, pointers and explicit occupancy counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < WbDepth; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr].addr <= i_push_addr;
                r_mem[r_wr_ptr].data <= MaxDataW'(i_push_data);
                r_wr_ptr             <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (i_push && !i_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!i_push && i_pop) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    assign o_pop_addr = r_mem[r_rd_ptr].addr;
    assign o_pop_data = r_mem[r_rd_ptr].data[DataWidth-1:0];
    assign o_full     = (32'(r_level) >= WbDepth);
    assign o_empty    = (r_level == '0);
    assign o_level    = r_level;

    // Walk oldest to youngest so the last match (the youngest) wins
    always_comb begin
        o_lookup_hit  = 1'b0;
        o_lookup_data = '0;
        w_idx         = '0;
        for (int unsigned k = 0; k < WbDepth; k++) begin
            w_idx = PtrW'((32'(r_rd_ptr) + k) % WbDepth);
            if ((k < 32'(r_level)) && (r_mem[w_idx].addr == i_lookup_addr)) begin
                o_lookup_hit  = 1'b1;
                o_lookup_data = r_mem[w_idx].data[DataWidth-1:0];
            end
        end
    end

endmodule

// File: rtl/ibex_l2_regfile_bank.sv
// Slow backing store for registers that miss in the L1 window: fixed-latency
// reads over valid/ready, writes posted through a small buffer drained when idle.
module ibex_l2_regfile_bank
    import ibex_l2rf_pkg::*;
#(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned ReadLatency = 2,
    parameter int unsigned WbDepth     = 2,
    parameter bit          RV32E       = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [RegAddrW-1:0]  req_addr_i,
    output logic                 rsp_valid_o,
    output logic [RegAddrW-1:0]  rsp_addr_o,
    output logic [DataWidth-1:0] rsp_rdata_o,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [RegAddrW-1:0]  wr_addr_i,
    input  logic [DataWidth-1:0] wr_data_i,
    output logic                 busy_o,
    output logic [WbLevelW-1:0]  wb_level_o
);

    l2rf_state_e          r_state;
    logic [LatCntW-1:0]   r_cnt;
    logic [RegAddrW-1:0]  r_req_addr;
    logic [DataWidth-1:0] r_req_data;
    logic                 r_rsp_valid;
    logic [RegAddrW-1:0]  r_rsp_addr;
    logic [DataWidth-1:0] r_rsp_rdata;
    logic [DataWidth-1:0] r_regs [NumRegs];

    logic                 w_full;
    logic                 w_empty;
    logic [WbLevelW-1:0]  w_level;
    logic                 w_req_fire;
    logic                 w_wr_addr_ok;
    logic                 w_push;
    logic                 w_pop;
    logic [RegAddrW-1:0]  w_pop_addr;
    logic [DataWidth-1:0] w_pop_data;
    logic                 w_hit;
    logic [DataWidth-1:0] w_hit_data;
    logic [DataWidth-1:0] w_rd_data;

    // A full buffer blocks reads so the drain is guaranteed to make progress
    assign req_ready_o  = (r_state == IDLE) && !w_full;
    assign wr_ready_o   = !w_full;
    assign w_req_fire   = req_valid_i && req_ready_o;
    // x0 and, on RV32E, x16..x31 do not exist: accept the write but drop it
    assign w_wr_addr_ok = (wr_addr_i != '0) && !(RV32E && wr_addr_i[RegAddrW-1]);
    assign w_push       = wr_valid_i && wr_ready_o && w_wr_addr_ok;
    assign w_pop        = (r_state == IDLE) && !w_empty && !w_req_fire;

    ibex_l2rf_wbuf #(
        .DataWidth (DataWidth),
        .WbDepth   (WbDepth)
    ) u_wbuf (
        .i_clk         (clk_i),
        .i_rst         (rst_i),
        .i_push        (w_push),
        .i_push_addr   (wr_addr_i),
        .i_push_data   (wr_data_i),
        .i_pop         (w_pop),
        .o_pop_addr    (w_pop_addr),
        .o_pop_data    (w_pop_data),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_level       (w_level),
        .i_lookup_addr (req_addr_i),
        .o_lookup_hit  (w_hit),
        .o_lookup_data (w_hit_data)
    );

    // Read snapshot source: zero for absent registers, else youngest buffered write, else array
    always_comb begin
        w_rd_data = '0;
        if ((req_addr_i == '0) || (RV32E && req_addr_i[RegAddrW-1])) begin
            w_rd_data = '0;
        end else if (w_hit) begin
            w_rd_data = w_hit_data;
        end else begin
            w_rd_data = r_regs[req_addr_i];
        end
    end

    // Array is written only from the drain, which only happens in IDLE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumRegs; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_pop) begin
            r_regs[w_pop_addr] <= w_pop_data;
        end
    end

    // Read FSM; r_cnt holds the cycles remaining until rsp_valid_o rises
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_req_addr  <= '0;
            r_req_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_req_fire) begin
                        if (ReadLatency == 1) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_addr  <= req_addr_i;
                            r_rsp_rdata <= w_rd_data;
                        end else begin
                            r_state    <= READ;
                            r_cnt      <= LatCntW'(ReadLatency - 1);
                            r_req_addr <= req_addr_i;
                            r_req_data <= w_rd_data;
                        end
                    end
                end
                READ: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == LatCntW'(1)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_addr  <= r_req_addr;
                        r_rsp_rdata <= r_req_data;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_addr_o  = r_rsp_addr;
    assign rsp_rdata_o = r_rsp_rdata;
    assign busy_o      = (r_state != IDLE) || (w_level != '0);
    assign wb_level_o  = w_level;

endmodule
